// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_if
//  Purpose  : Request/response bundle for the sequential ALU. It carries the
//             request handshake with its operands, the response handshake with
//             the registered result and flags, and the busy indicator.
//  Ports    : master - request producer / result consumer (drives in_valid,
//                      A, B, ALUop, out_ready)
//             slave  - the ALU (drives in_ready, out_valid, Result, Overflow,
//                      CarryOut, Zero, busy)
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [3:0]            ALUop;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] Result;
  logic                  Overflow;
  logic                  CarryOut;
  logic                  Zero;
  logic                  busy;

  modport master (
    output in_valid, A, B, ALUop, out_ready,
    input  in_ready, out_valid, Result, Overflow, CarryOut, Zero, busy
  );

  modport slave (
    input  in_valid, A, B, ALUop, out_ready,
    output in_ready, out_valid, Result, Overflow, CarryOut, Zero, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Handshaked ALU. One operation at a time is accepted over a
//             valid/ready request; result and flags are registered and offered
//             over a valid/ready response. Single-cycle ops have latency 1 and
//             can stream at one per cycle. MUL is an iterative shift-add unit.
//  Ports    : clk    - clock, rising edge
//             resetn - asynchronous active-low reset
//             bus    - alu_seq_if.slave (in_valid/in_ready, A, B, ALUop,
//                      out_valid/out_ready, Result, Overflow, CarryOut, Zero,
//                      busy)
//  Config   : ALU_MUL_EN - when defined, opcode 1000 (MUL) and the BUSY state,
//             accumulator and counter are built. When undefined, 1000 behaves
//             as an unlisted opcode and busy is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic       clk,
  input  logic       resetn,
  alu_seq_if.slave   bus
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int MSB = DATA_WIDTH - 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic accept;
  logic is_mul_op;
  logic mul_finish;

  logic [DATA_WIDTH-1:0] result_q;
  logic                  overflow_q;
  logic                  carry_q;
  logic                  zero_q;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign accept        = bus.in_valid & bus.in_ready;

  // --------------------------------------------------------------------------
  // Single-cycle datapath (operands taken straight from the bus; the result
  // is only captured on the accept edge, so later operand changes are moot)
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH:0]   sum_ext;
  logic [DATA_WIDTH:0]   diff_ext;
  logic                  add_ovf;
  logic                  sub_ovf;
  logic                  borrow;
  logic [SHW-1:0]        shamt;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_ovf;
  logic                  alu_cout;

  assign sum_ext  = {1'b0, bus.A} + {1'b0, bus.B};
  assign diff_ext = {1'b0, bus.A} + {1'b0, ~bus.B} + {{DATA_WIDTH{1'b0}}, 1'b1};
  assign add_ovf  = (bus.A[MSB] == bus.B[MSB]) & (sum_ext[MSB] != bus.A[MSB]);
  assign sub_ovf  = (bus.A[MSB] != bus.B[MSB]) & (diff_ext[MSB] != bus.A[MSB]);
  assign borrow   = ~diff_ext[DATA_WIDTH];
  assign shamt    = bus.B[SHW-1:0];

  always_comb begin
    alu_res  = '0;
    alu_ovf  = 1'b0;
    alu_cout = 1'b0;
    case (bus.ALUop)
      OP_AND:  alu_res = bus.A & bus.B;
      OP_OR:   alu_res = bus.A | bus.B;
      OP_XOR:  alu_res = bus.A ^ bus.B;
      OP_NOR:  alu_res = ~(bus.A | bus.B);
      OP_ADD: begin
        alu_res  = sum_ext[MSB:0];
        alu_cout = sum_ext[DATA_WIDTH];
        alu_ovf  = add_ovf;
      end
      OP_SUB: begin
        alu_res  = diff_ext[MSB:0];
        alu_cout = borrow;
        alu_ovf  = sub_ovf;
      end
      OP_SLT: begin
        // Sign of the difference corrected by overflow gives signed A < B.
        alu_res  = {{(DATA_WIDTH-1){1'b0}}, diff_ext[MSB] ^ sub_ovf};
        alu_cout = borrow;
        alu_ovf  = sub_ovf;
      end
      OP_SLTU: begin
        alu_res  = {{(DATA_WIDTH-1){1'b0}}, borrow};
        alu_cout = borrow;
      end
      OP_SLL:  alu_res = bus.A << shamt;
      OP_SRL:  alu_res = bus.A >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.A) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Iterative shift-add multiplier
  // --------------------------------------------------------------------------
`ifdef ALU_MUL_EN
  localparam int               CW         = SHW + 1;
  localparam logic [3:0]       OP_MUL     = 4'b1000;
  localparam logic [CW-1:0]    COUNT_LAST = CW'(DATA_WIDTH);

  logic [2*DATA_WIDTH-1:0] mcand_q;
  logic [DATA_WIDTH-1:0]   mplier_q;
  logic [2*DATA_WIDTH-1:0] acc_q;
  logic [CW-1:0]           count_q;
  logic                    count_done;

  assign is_mul_op  = (bus.ALUop == OP_MUL);
  assign count_done = (count_q == COUNT_LAST);
  // The BUSY state spends DATA_WIDTH cycles iterating and one more cycle
  // writing the product out; busy reflects the iterating part only.
  assign mul_finish = (state == BUSY) & count_done;
  assign bus.busy   = (state == BUSY) & ~count_done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else if (accept && is_mul_op) begin
      mcand_q  <= {{DATA_WIDTH{1'b0}}, bus.A};
      mplier_q <= bus.B;
      acc_q    <= '0;
      count_q  <= '0;
    end else if ((state == BUSY) && !count_done) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q + 1'b1;
    end
  end
`else
  assign is_mul_op  = 1'b0;
  assign mul_finish = 1'b0;
  assign bus.busy   = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = is_mul_op ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (mul_finish) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (accept) begin
          state_nxt = is_mul_op ? BUSY : DONE;
        end else if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Result / flag registers (hold whenever nothing new is written)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b1;
    end else if (accept && !is_mul_op) begin
      result_q   <= alu_res;
      overflow_q <= alu_ovf;
      carry_q    <= alu_cout;
      zero_q     <= (alu_res == '0);
    end
`ifdef ALU_MUL_EN
    else if (mul_finish) begin
      result_q   <= acc_q[DATA_WIDTH-1:0];
      overflow_q <= |acc_q[2*DATA_WIDTH-1:DATA_WIDTH];
      carry_q    <= 1'b0;
      zero_q     <= (acc_q[DATA_WIDTH-1:0] == '0);
    end
`endif
  end

  assign bus.Result   = result_q;
  assign bus.Overflow = overflow_q;
  assign bus.CarryOut = carry_q;
  assign bus.Zero     = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Self-checking bench for alu_seq (DATA_WIDTH = 32). Directed
//             vector table, hand-written handshake/reset sequences and random
//             operations compared against an arithmetic reference model.
//             Honours ALU_MUL_EN in the same way as the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  localparam int DW = 32;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic clk;
  logic resetn;

  alu_seq_if #(.DATA_WIDTH(DW)) bus ();

  alu_seq #(.DATA_WIDTH(DW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        cout;
    logic        zero;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] r, input logic o, input logic c, input logic z);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = r; v.ovf = o; v.cout = c; v.zero = z;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit mul_enabled();
`ifdef ALU_MUL_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: computed from the arithmetic meaning of each opcode.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic o, output logic c);
    longint          sa, sb, s, t;
    longint unsigned ua, ub, u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r = '0; o = 1'b0; c = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0011: r = a ^ b;
      4'b0100: r = ~(a | b);
      4'b0010: begin
        u = ua + ub; s = sa + sb;
        r = u[31:0]; c = u[32]; o = (s > MAXS) || (s < MINS);
      end
      4'b0110: begin
        s = sa - sb;
        r = a - b; c = (a < b); o = (s > MAXS) || (s < MINS);
      end
      4'b0111: begin
        s = sa - sb;
        r = (sa < sb) ? 32'd1 : 32'd0; c = (a < b); o = (s > MAXS) || (s < MINS);
      end
      4'b0101: r = (a < b) ? 32'd1 : 32'd0;
      4'b1001: r = a << b[4:0];
      4'b1010: r = a >> b[4:0];
      4'b1011: begin
        t = sa >>> b[4:0];
        r = t[31:0];
      end
      4'b0101 + 4'b0011: begin   // 1000: MUL when built in
        if (mul_enabled()) begin
          u = ua * ub;
          r = u[31:0]; o = (u[63:32] != 0);
        end
      end
      default: r = '0;
    endcase
    if (op == 4'b0101) c = (a < b);
  endfunction

  // Issue one operation (out_ready assumed high unless the caller lowered it)
  // and wait for its response. Operands are scrambled after the accept edge.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic o, output logic c, output logic z,
                        output int lat, output int busy_cnt, output int ready_bad);
    int n;
    bus.ALUop = op; bus.A = a; bus.B = b; bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_timeout", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.A = $urandom; bus.B = $urandom; bus.ALUop = 4'($urandom);
    lat = 1; busy_cnt = 0; ready_bad = 0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.busy) busy_cnt++;
      if (bus.in_ready) ready_bad++;
      @(posedge clk); #1; lat++;
    end
    r = bus.Result; o = bus.Overflow; c = bus.CarryOut; z = bus.Zero;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, er;
    logic        o, c, z, eo, ec;
    int          lat, bc, rb;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [31:0] exp_b2b [4];
    bit          mul;

    mul = mul_enabled();

    vecs.push_back(mk(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1, 0, 0));
    vecs.push_back(mk(4'b0110, 32'd5,         32'd5,         32'h0000_0000, 0, 0, 1));
    vecs.push_back(mk(4'b0111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1, 0, 0));
    vecs.push_back(mk(4'b0101, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 0, 0, 1));
    vecs.push_back(mk(4'b1011, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 0, 0, 0));
    vecs.push_back(mk(4'b1001, 32'h0000_0001, 32'd31,        32'h8000_0000, 0, 0, 0));
    vecs.push_back(mk(4'b1010, 32'h8000_0000, 32'd4,         32'h0800_0000, 0, 0, 0));
    vecs.push_back(mk(4'b0011, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 0, 0, 0));
    vecs.push_back(mk(4'b0100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0, 0));
    vecs.push_back(mk(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0, 0, 0));
    vecs.push_back(mk(4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 0, 0, 0));
    vecs.push_back(mk(4'b0110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 0, 1, 0));
    vecs.push_back(mk(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0, 1, 1));
    vecs.push_back(mk(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 0, 0, 1));
    vecs.push_back(mk(4'b1000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, mul, 0, 1));
    vecs.push_back(mk(4'b1000, 32'd7,         32'd6,         mul ? 32'd42 : 32'd0, 0, 0, !mul));

    // ---------------- reset state ----------------
    resetn = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.A = '0; bus.B = '0; bus.ALUop = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_busy",      {63'd0, bus.busy},      64'd0);
    chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
    chk("rst_result",    {32'd0, bus.Result},    64'd0);
    chk("rst_flags",     {61'd0, bus.Overflow, bus.CarryOut, bus.Zero}, 64'b001);

    // ---------------- directed vector table ----------------
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, o, c, z, lat, bc, rb);
      chk($sformatf("vec%0d_result", i), {32'd0, r}, {32'd0, vecs[i].res});
      chk($sformatf("vec%0d_ovf", i),  {63'd0, o}, {63'd0, vecs[i].ovf});
      chk($sformatf("vec%0d_cout", i), {63'd0, c}, {63'd0, vecs[i].cout});
      chk($sformatf("vec%0d_zero", i), {63'd0, z}, {63'd0, vecs[i].zero});
      if (mul && vecs[i].op == 4'b1000) begin
        chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
        chk($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd32);
        chk($sformatf("vec%0d_ready_while_busy", i), 64'(rb), 64'd0);
      end else begin
        chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd1);
      end
    end

    // ---------------- back-to-back ADDs ----------------
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.ALUop = 4'b0010; bus.A = 32'(100 * k); bus.B = 32'(k + 7);
      exp_b2b[k] = 32'(100 * k + k + 7);
      chk($sformatf("b2b%0d_in_ready", k), {63'd0, bus.in_ready}, 64'd1);
      @(posedge clk); #1;
      chk($sformatf("b2b%0d_out_valid", k), {63'd0, bus.out_valid}, 64'd1);
      chk($sformatf("b2b%0d_result", k), {32'd0, bus.Result}, {32'd0, exp_b2b[k]});
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_drain_out_valid", {63'd0, bus.out_valid}, 64'd0);

    // ---------------- backpressure hold ----------------
    bus.out_ready = 1'b0;
    run_op(4'b0010, 32'd10, 32'd20, r, o, c, z, lat, bc, rb);
    chk("hold_first_result", {32'd0, r}, 64'd30);
    bus.in_valid = 1'b1; bus.ALUop = 4'b0110; bus.A = 32'd100; bus.B = 32'd1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold%0d_in_ready", k), {63'd0, bus.in_ready}, 64'd0);
      @(posedge clk); #1;
      chk($sformatf("hold%0d_result", k), {32'd0, bus.Result}, 64'd30);
      chk($sformatf("hold%0d_out_valid", k), {63'd0, bus.out_valid}, 64'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("hold_release_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("hold_replace_result", {32'd0, bus.Result}, 64'd99);
    chk("hold_replace_valid", {63'd0, bus.out_valid}, 64'd1);
    @(posedge clk); #1;
    chk("hold_drain_valid", {63'd0, bus.out_valid}, 64'd0);

    // ---------------- asynchronous reset ----------------
    bus.out_ready = 1'b0;
    run_op(4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFE, r, o, c, z, lat, bc, rb);
    chk("prerst_result", {32'd0, r}, 64'hFFFF_FFFD);
    bus.out_ready = 1'b1;
`ifdef ALU_MUL_EN
    // Start a MUL and reset it at iteration 10.
    bus.ALUop = 4'b1000; bus.A = 32'h0001_0000; bus.B = 32'h0001_0000; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_mul_busy", {63'd0, bus.busy}, 64'd1);
`endif
    #2 resetn = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("arst_busy",      {63'd0, bus.busy},      64'd0);
    chk("arst_result",    {32'd0, bus.Result},    64'd0);
    chk("arst_flags",     {61'd0, bus.Overflow, bus.CarryOut, bus.Zero}, 64'b001);
    chk("arst_in_ready",  {63'd0, bus.in_ready},  64'd1);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("post_rst_no_valid",   {63'd0, bus.out_valid}, 64'd0);
    run_op(4'b0010, 32'd2, 32'd3, r, o, c, z, lat, bc, rb);
    chk("post_rst_add", {32'd0, r}, 64'd5);
    chk("post_rst_add_latency", 64'(lat), 64'd1);

    // ---------------- randomized against reference model ----------------
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = pick_operand();
      b  = pick_operand();
      model(op, a, b, er, eo, ec);
      run_op(op, a, b, r, o, c, z, lat, bc, rb);
      chk($sformatf("rnd%0d_op%0h_result", i, op), {32'd0, r}, {32'd0, er});
      chk($sformatf("rnd%0d_op%0h_flags", i, op), {61'd0, o, c, z}, {61'd0, eo, ec, (er == 32'd0)});
      chk($sformatf("rnd%0d_op%0h_latency", i, op), 64'(lat),
          (mul && op == 4'b1000) ? 64'd33 : 64'd1);
    end

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Handshaked, parametrised ALU for the CPU datapath. It accepts one operation at a time over a valid/ready interface and registers the result and flags. Single-cycle operations complete with 1-cycle latency. An optional iterative shift-add multiplier takes DATA_WIDTH+1 cycles. Opcodes 0000/0001/0010/0110/0111 keep the existing AND/OR/ADD/SUB/SLT semantics, and new opcodes add XOR, NOR, SLTU, shifts and MUL.

## Interface
- DATA_WIDTH, 32, operand/result width; power of two, ≥4
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  reset, asynchronous, active-low
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- A  in  DATA_WIDTH  operand A
- B  in  DATA_WIDTH  operand B; B[log2(DATA_WIDTH)-1:0] is the shift amount for shifts
- ALUop  in  4  opcode
- out_valid  out  1  Result/flags valid
- out_ready  in  1  consumer takes result
- Result  out  DATA_WIDTH  registered result
- Overflow, CarryOut, Zero  out  1 each  registered flags
- busy  out  1  high in BUSY

## Operation
- Opcodes and flags:
  - 0000 AND, 0001 OR, 0011 XOR, 0100 NOR.
  - 0010 ADD: CarryOut is the carry out, Overflow is signed overflow.
  - 0110 SUB: computes A+~B+1. CarryOut = !carry (borrow). Overflow is signed overflow.
  - 0111 SLT: Result = {0…, sign(A-B)^sub_overflow}. Overflow and CarryOut are as for SUB.
  - 0101 SLTU: Result = {0…, borrow}. CarryOut = borrow, Overflow = 0.
  - 1001 SLL, 1010 SRL, 1011 SRA: Overflow = CarryOut = 0.
  - 1000 MUL: unsigned; Result = low DATA_WIDTH bits of the product. Overflow = 1 if the high half of the product is nonzero. CarryOut = 0.
  - Logic ops: Overflow = CarryOut = 0.
  - All other opcodes: Result = 0, Overflow = CarryOut = 0.
- Zero = (Result == 0) for every opcode. It is registered together with Result.
- States:
  - IDLE: in_ready = 1.
    - Accepting a non-MUL op goes to DONE.
    - Accepting MUL loads the multiplicand, multiplier and a zero accumulator (2·DATA_WIDTH bits), clears the counter and goes to BUSY.
  - BUSY: each cycle, if multiplier[0] is set, add the shifted multiplicand to the accumulator. Then shift the multiplicand left and the multiplier right, and increment the counter. After DATA_WIDTH iterations, write Result/flags and go to DONE.
  - DONE: out_valid = 1.
    - If out_ready, the state leaves DONE: to IDLE, or directly to DONE/BUSY if a new request is accepted in the same cycle.
- in_ready = IDLE | (DONE & out_ready). This allows back-to-back single-cycle ops at one per cycle.
- Operands and opcode are sampled only on the accept edge (in_valid & in_ready). Input changes afterwards do not affect the operation in flight.
- Result and flags hold stable while out_valid=1 and out_ready=0.
- Reset (async, any state, including mid-MUL):
  - state → IDLE, counter and accumulator cleared.
  - out_valid, busy, Result, Overflow, CarryOut = 0; Zero = 1.
  - The in-flight operation is discarded.

## Timing
- Non-MUL: accept at edge N → out_valid=1 after edge N+1. Latency 1.
- MUL: accept at edge N → busy for edges N+1…N+DATA_WIDTH → out_valid=1 after edge N+DATA_WIDTH+1.
- Throughput: 1/cycle for non-MUL when out_ready is held high. MUL blocks new requests while BUSY.
- Simultaneous events:
  - Result taken and a new request accepted on the same edge: the new result replaces the old one on that edge, and out_valid stays 1.
  - Result taken with no new request: out_valid drops after that edge.
- Outputs are registered only. There is no combinational path from A/B/ALUop to Result.

## Configuration
- ALU_MUL_EN defined: MUL opcode 1000 and the BUSY state, accumulator and counter are compiled in.
- ALU_MUL_EN undefined:
  - 1000 is an unlisted opcode: single-cycle, Result = 0, Overflow = CarryOut = 0, Zero = 1.
  - busy is tied 0. No multiplier logic is present.

## Test plan
- DATA_WIDTH=32, ADD 0x7FFF_FFFF+0x0000_0001 → next cycle out_valid=1, Result=0x8000_0000, Overflow=1, CarryOut=0, Zero=0.
- SUB 5-5 → Result=0, Zero=1, CarryOut=0. SLT 0x8000_0000,0x1 → Result=1. SLTU same operands → Result=0.
- SRA 0x8000_0000 by B=0x21 (amount 1) → 0xC000_0000. SLL 0x1 by 31 → 0x8000_0000.
- MUL (ALU_MUL_EN) 0x0001_0000×0x0001_0000:
  - busy for 32 cycles, out_valid 33 cycles after accept.
  - Result=0, Overflow=1, Zero=1.
  - in_ready=0 while busy.
- Back-to-back: 4 ADDs with in_valid and out_ready high every cycle → 4 consecutive out_valid cycles. With out_ready=0 in DONE → Result holds and in_ready=0.
- Assert resetn low at MUL iteration 10 → outputs at reset values immediately, in IDLE after release. The next ADD 2+3 → Result=5.
